// File: rtl/andrew_damasta.sv
// andrew_damasta: 8-bit accumulator ALU for the tiny-tapeout tile.
// A command runs once per rising edge of the strobe (ui_in[3]). The
// accumulator or the status byte is muxed onto uo_out by ui_in[7].
module andrew_damasta (
  input  logic       clk,
  input  logic       rst_n,   // active-high synchronous reset despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_SHIFT = 3'd7
  } op_e;

  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d;
  logic       n_q, n_d;
  logic       c_q, c_d;
  logic       v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stb_q, stb_d;

  op_e        op_s;
  logic       mod_s;
  logic [7:0] opb_s;
  logic       exec_s;
  logic       cin_s;
  logic [8:0] sum_s;
  logic [8:0] diff_s;
  logic [7:0] res_s;

  // Only bits 6:5 of the command bus carry no meaning.
  logic       unused_s;
  assign unused_s = &{1'b0, ui_in[6:5]};

  // Decode the command bus and compute the next register state.
  always_comb begin
    op_s   = op_e'(ui_in[2:0]);
    mod_s  = ui_in[4];
    opb_s  = uio_in;
    // Execute only on a fresh strobe rising edge while enabled.
    exec_s = ena & ui_in[3] & ~stb_q;
    cin_s  = mod_s & c_q;
    // 9-bit arithmetic: bit 8 is carry-out for ADD and borrow for SUB.
    sum_s  = {1'b0, acc_q} + {1'b0, opb_s} + {8'h00, cin_s};
    diff_s = {1'b0, acc_q} - {1'b0, opb_s} - {8'h00, cin_s};
    res_s  = acc_q;
    acc_d  = acc_q;
    z_d    = z_q;
    n_d    = n_q;
    c_d    = c_q;
    v_d    = v_q;
    cnt_d  = cnt_q;
    stb_d  = ui_in[3];
    if (exec_s) begin
      cnt_d = cnt_q + 4'd1;
      case (op_s)
        OP_NOP: begin
          res_s = acc_q;
        end
        OP_LOAD: begin
          res_s = opb_s;
          c_d   = 1'b0;
          v_d   = 1'b0;
        end
        OP_ADD: begin
          res_s = sum_s[7:0];
          c_d   = sum_s[8];
          v_d   = (acc_q[7] == opb_s[7]) && (sum_s[7] != acc_q[7]);
        end
        OP_SUB: begin
          res_s = diff_s[7:0];
          c_d   = diff_s[8];
          v_d   = (acc_q[7] != opb_s[7]) && (diff_s[7] != acc_q[7]);
        end
        OP_AND: begin
          res_s = acc_q & opb_s;
          c_d   = 1'b0;
          v_d   = 1'b0;
        end
        OP_OR: begin
          res_s = acc_q | opb_s;
          c_d   = 1'b0;
          v_d   = 1'b0;
        end
        OP_XOR: begin
          res_s = acc_q ^ opb_s;
          c_d   = 1'b0;
          v_d   = 1'b0;
        end
        OP_SHIFT: begin
          if (mod_s) begin
            res_s = {1'b0, acc_q[7:1]};
            c_d   = acc_q[0];
          end else begin
            res_s = {acc_q[6:0], 1'b0};
            c_d   = acc_q[7];
          end
          v_d = 1'b0;
        end
        default: begin
          res_s = acc_q;
        end
      endcase
      // NOP leaves the accumulator and every flag untouched.
      if (op_s != OP_NOP) begin
        acc_d = res_s;
        z_d   = (res_s == 8'h00);
        n_d   = res_s[7];
      end else begin
        acc_d = acc_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset wins over a coinciding strobe.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_q <= 8'h00;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      cnt_q <= 4'd0;
      stb_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      z_q   <= z_d;
      n_q   <= n_d;
      c_q   <= c_d;
      v_q   <= v_d;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  // Output view select: accumulator or status byte, no side effects.
  always_comb begin
    if (ui_in[7]) begin
      uo_out = {cnt_q, v_q, c_q, n_q, z_q};
    end else begin
      uo_out = acc_q;
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_andrew_damasta.sv
// Self-checking bench for andrew_damasta: expected {A, status} pairs are
// queued when a command is driven and popped when the DUT result is visible.
module tb_andrew_damasta;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb [$];

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, SHIFT = 3'd7;

  always #5 clk = ~clk;

  andrew_damasta dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Drive one strobed command and queue its expected outcome.
  task automatic issue(input logic [2:0] op, input logic m, input logic [7:0] b,
                       input logic [7:0] ea, input logic [7:0] es);
    @(negedge clk);
    ui_in  = {1'b0, 2'b00, m, 1'b1, op};
    uio_in = b;
    sb.push_back({ea, es});
    @(posedge clk);
    #1;
  endtask

  task automatic release_strobe();
    @(negedge clk);
    ui_in[3] = 1'b0;
    ui_in[7] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ena    = 1'b1;
    rst_n  = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    do_reset();
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_A got %h want 00", uo_out); end
    ui_in[7] = 1'b1;
    #1;
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", uo_out); end
    checks++;
    if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_uio_oe got %h want 00", uio_oe); end
    checks++;
    if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h want 00", uio_out); end
    ui_in[7] = 1'b0;
  endtask

  // Table: {reset_first, op, M, B, expected A, expected status}
  task automatic test_arith();
    logic [28:0] tbl [0:16];
    logic [15:0] e;
    tbl = '{
      {1'b1, LOAD,  1'b0, 8'h7F, 8'h7F, 8'h10},
      {1'b0, ADD,   1'b0, 8'h01, 8'h80, 8'h2A},
      {1'b1, LOAD,  1'b0, 8'hFF, 8'hFF, 8'h12},
      {1'b0, ADD,   1'b0, 8'h01, 8'h00, 8'h25},
      {1'b0, ADD,   1'b1, 8'h00, 8'h01, 8'h30},
      {1'b1, LOAD,  1'b0, 8'h00, 8'h00, 8'h11},
      {1'b0, SUB,   1'b0, 8'h01, 8'hFF, 8'h26},
      {1'b0, SHIFT, 1'b1, 8'h00, 8'h7F, 8'h34},
      {1'b0, SUB,   1'b1, 8'h0F, 8'h6F, 8'h40},
      {1'b0, AND_,  1'b0, 8'hF0, 8'h60, 8'h50},
      {1'b0, OR_,   1'b0, 8'h81, 8'hE1, 8'h62},
      {1'b0, XOR_,  1'b0, 8'hE1, 8'h00, 8'h71},
      {1'b0, OR_,   1'b0, 8'hC0, 8'hC0, 8'h82},
      {1'b0, SHIFT, 1'b0, 8'h00, 8'h80, 8'h96},
      {1'b0, SUB,   1'b0, 8'h01, 8'h7F, 8'hA8},
      {1'b0, ADD,   1'b1, 8'h80, 8'hFF, 8'hB2},
      {1'b0, NOP,   1'b0, 8'h33, 8'hFF, 8'hC2}
    };
    for (int i = 0; i < 17; i++) begin
      if (tbl[i][28]) do_reset();
      issue(tbl[i][27:25], tbl[i][24], tbl[i][23:16], tbl[i][15:8], tbl[i][7:0]);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL arith_%0d scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if (uo_out !== e[15:8]) begin errors++; $display("FAIL arith_%0d_A got %h want %h", i, uo_out, e[15:8]); end
        ui_in[7] = 1'b1;
        #1;
        checks++;
        if (uo_out !== e[7:0]) begin errors++; $display("FAIL arith_%0d_status got %h want %h", i, uo_out, e[7:0]); end
      end
      release_strobe();
    end
  endtask

  task automatic test_strobe_hold();
    logic [15:0] e;
    do_reset();
    issue(ADD, 1'b0, 8'h01, 8'h01, 8'h10);
    repeat (9) @(posedge clk);
    #1;
    checks++;
    e = sb.pop_front();
    if (uo_out !== e[15:8]) begin errors++; $display("FAIL hold_A got %h want %h", uo_out, e[15:8]); end
    ui_in[7] = 1'b1;
    #1;
    checks++;
    if (uo_out !== e[7:0]) begin errors++; $display("FAIL hold_status got %h want %h", uo_out, e[7:0]); end
    release_strobe();
  endtask

  task automatic test_cnt_wrap();
    logic [15:0] e;
    logic [3:0]  c;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      c = 4'(i % 16);
      issue(NOP, 1'b0, 8'hA5, 8'h00, {c, 4'h0});
      e = sb.pop_front();
      checks++;
      if (uo_out !== e[15:8]) begin errors++; $display("FAIL wrap_%0d_A got %h want %h", i, uo_out, e[15:8]); end
      ui_in[7] = 1'b1;
      #1;
      checks++;
      if (uo_out !== e[7:0]) begin errors++; $display("FAIL wrap_%0d_status got %h want %h", i, uo_out, e[7:0]); end
      release_strobe();
    end
  endtask

  // Continues from the wrap test state: A=00, CNT=1.
  task automatic test_ena_low();
    logic [15:0] e;
    @(negedge clk);
    ena = 1'b0;
    issue(LOAD, 1'b0, 8'h55, 8'h00, 8'h10);
    e = sb.pop_front();
    checks++;
    if (uo_out !== e[15:8]) begin errors++; $display("FAIL ena0_A got %h want %h", uo_out, e[15:8]); end
    @(negedge clk);
    ena = 1'b1;
    sb.push_back({8'h00, 8'h10});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    ui_in[7] = 1'b1;
    #1;
    checks++;
    if (uo_out !== e[7:0]) begin errors++; $display("FAIL ena_rise_status got %h want %h", uo_out, e[7:0]); end
    release_strobe();
    issue(LOAD, 1'b0, 8'h55, 8'h55, 8'h20);
    e = sb.pop_front();
    checks++;
    if (uo_out !== e[15:8]) begin errors++; $display("FAIL ena1_A got %h want %h", uo_out, e[15:8]); end
    ui_in[7] = 1'b1;
    #1;
    checks++;
    if (uo_out !== e[7:0]) begin errors++; $display("FAIL ena1_status got %h want %h", uo_out, e[7:0]); end
    release_strobe();
  endtask

  task automatic test_reset_collision();
    logic [15:0] e;
    @(negedge clk);
    rst_n  = 1'b1;
    ui_in  = {1'b0, 2'b00, 1'b0, 1'b1, LOAD};
    uio_in = 8'h55;
    sb.push_back({8'h00, 8'h00});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (uo_out !== e[15:8]) begin errors++; $display("FAIL collide_A got %h want %h", uo_out, e[15:8]); end
    // Strobe still high as reset releases: executes at the first free edge.
    @(negedge clk);
    rst_n = 1'b0;
    sb.push_back({8'h55, 8'h10});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (uo_out !== e[15:8]) begin errors++; $display("FAIL post_reset_A got %h want %h", uo_out, e[15:8]); end
    ui_in[7] = 1'b1;
    #1;
    checks++;
    if (uo_out !== e[7:0]) begin errors++; $display("FAIL post_reset_status got %h want %h", uo_out, e[7:0]); end
    release_strobe();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_strobe_hold();
    test_cnt_wrap();
    test_ena_low();
    test_reset_collision();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/andrew_damasta.md
# andrew_damasta

Top-level user block for the team's tiny-tapeout tile: an 8-bit accumulator ALU driven through the standard tile pins. A command is executed once per rising edge of a strobe input. The accumulator or a status byte is presented on the dedicated outputs. The block sits directly under the tile harness and has no sub-modules beyond its own registers.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-high (asserted = 1, despite the name).
- `ena`  in  1  block enable; when 0, no command executes and all state holds.
- `ui_in`  in  8  command bus:
  - [2:0] opcode
  - [3] strobe
  - [4] modifier M
  - [6:5] ignored
  - [7] output select S
- `uio_in`  in  8  operand B.
- `uo_out`  out  8  S=0: accumulator A; S=1: status byte {CNT[3:0], V, C, N, Z}.
- `uio_out`  out  8  constant 0x00.
- `uio_oe`  out  8  constant 0x00 (all bidirectional pins are inputs).

## Operation
- State registers:
  - A[7:0] accumulator
  - flags Z, N, C, V
  - CNT[3:0] executed-command counter
  - STB_Q (previous strobe)
- Execute condition at a rising edge: `ena`=1, ui_in[3]=1, STB_Q=0. Opcode, M and B are sampled at that same edge.
- STB_Q <= ui_in[3] on every edge, regardless of `ena`.
- Opcodes, with R = result written to A:
  - 0 NOP: A and flags unchanged.
  - 1 LOAD: R=B; C=0, V=0.
  - 2 ADD: {C,R} = A + B + (M ? C : 0). V = (A[7]==B[7]) && (R[7]!=A[7]).
  - 3 SUB: R = A − B − (M ? C : 0). C = 1 if the unsigned result borrowed (A < B + cin). V = (A[7]!=B[7]) && (R[7]!=A[7]).
  - 4 AND, 5 OR, 6 XOR: R = A op B; C=0, V=0.
  - 7 SHIFT: M=0 shifts left (C=A[7], R={A[6:0],0}). M=1 shifts right logically (C=A[0], R={0,A[7:1]}). V=0.
- For every opcode except NOP: Z = (R==0), N = R[7].
- CNT increments by 1 on every executed command, NOP included. It wraps 15 -> 0.
- Arithmetic is modulo 256. The carry-in for ADD/SUB with M=1 is the C flag value before the edge.
- `uo_out` is a combinational mux of registered state controlled by ui_in[7]. It changes immediately when S changes and has no side effects.
- Strobe held high for many cycles executes exactly once. A new execution requires strobe low for at least one sampled edge.
- Strobe rising while `ena`=0 is lost. Because STB_Q still updates, raising `ena` while the strobe is already high does not execute.

## Timing
- Reset (`rst_n`=1 at an edge) sets A=0x00, Z=N=C=V=0, CNT=0, STB_Q=0.
  - `uo_out`=0x00 for both S values; `uio_out`=`uio_oe`=0x00.
- Reset has priority over execution at the same edge. A strobe edge coinciding with reset is discarded.
- After reset, STB_Q=0: a strobe held high through reset release executes at the first non-reset edge.
- Latency: the result appears on `uo_out` immediately after the executing edge (1 cycle from strobe sampled high).
- Back-to-back commands need at least 2 cycles: strobe high 1 edge, low 1 edge.
- No pipeline and no busy state; every command completes in one cycle.

## Test plan
- Reset with `rst_n`=1 for 2 cycles, then S=0 and S=1 → `uo_out`=0x00 in both views; `uio_oe`=0x00.
- LOAD B=0x7F, then ADD B=0x01 → A=0x80; status = CNT=2, V=1, C=0, N=1, Z=0, giving S=1 `uo_out`=0x2A.
- LOAD 0xFF, then ADD 0x01 → A=0x00, C=1, Z=1. Then ADD with M=1, B=0x00 → A=0x01, C=0, Z=0.
- LOAD 0x00, then SUB 0x01 → A=0xFF, C=1, N=1, V=0. Then SHIFT M=1 → A=0x7F, C=1, N=0.
- Strobe held high for 10 cycles with ADD B=0x01 from A=0x00 → A=0x01, CNT advanced by exactly 1.
- Seventeen NOP strobes after reset → CNT=1 (wrap), A unchanged.
- Strobe with `ena`=0 → no change.
- Reset asserted on the same edge as a LOAD 0x55 strobe → A=0x00.
